// File: rtl/fifo_uart_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
// Optional even parity is enabled with macro FIFO_UART_TX_PARITY_EN.
package fifo_uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_DATA_W       = 8;

    // PARITY keeps its code in every build so the encoding never shifts.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and wraps, ticking on the last count.
// Held at zero (no tick) while clr is high.
module baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a synchronous FIFO and sends 8N1 frames.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_W       = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [DATA_W-1:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic              bit_tick;
    logic              baud_clr;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              parity_bit;
`endif

    baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .clr      (baud_clr),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    shreg   <= fifo_rd_data;
                    bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_bit <= ^fifo_rd_data;
`endif
                end
                DATA: begin
                    if (bit_tick) begin
                        shreg <= shreg >> 1;
                        if (bit_cnt != LAST_BIT) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        tx         = 1'b1;
        busy       = 1'b1;
        tx_done    = 1'b0;
        baud_clr   = 1'b0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                baud_clr = 1'b1;
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_next = POP;
                end
            end
            POP: begin
                baud_clr   = 1'b1;
                state_next = LOAD;
            end
            LOAD: begin
                baud_clr   = 1'b1;
                state_next = START;
            end
            START: begin
                tx = 1'b0;
                if (bit_tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx = shreg[0];
                if (bit_tick && (bit_cnt == LAST_BIT)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
            PARITY: begin
`ifdef FIFO_UART_TX_PARITY_EN
                tx = parity_bit;
                if (bit_tick) begin
                    state_next = STOP;
                end
`else
                state_next = IDLE;
`endif
            end
            STOP: begin
                if (bit_tick) begin
                    tx_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
        // A reset cycle already looks like IDLE on the outputs.
        if (rst) begin
            fifo_rd_en = 1'b0;
            tx         = 1'b1;
            busy       = 1'b0;
            tx_done    = 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a behavioural sync FIFO in front.
// Build with FIFO_UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_fifo_uart_tx;

    localparam int CPB = 16;
    localparam int DW  = 8;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;
    logic          tx_done;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .tx           (tx),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    // clock
    always #5 clk = ~clk;

    // behavioural FIFO: bench writes mem/wr_ptr, read side pops on fifo_rd_en
    logic [DW-1:0] mem [64];
    logic [5:0]    wr_ptr;
    logic [5:0]    rd_ptr = '0;
    logic          force_empty;
    assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

    initial fifo_rd_data = '0;
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 6'd1;
        end
    end

    int rd_pulses = 0;
    int rd_viol   = 0;
    always @(posedge clk) begin
        if (fifo_rd_en === 1'b1) rd_pulses++;
        if (fifo_rd_en === 1'b1 && fifo_empty === 1'b1) rd_viol++;
    end

    // scoreboard
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 6'd1;
    endtask

    // Waits for a start bit, then samples the whole frame cycle by cycle.
    task automatic get_frame(input string tag, output logic [10:0] bits, output int gap);
        bit found    = 1'b0;
        bit stable   = 1'b1;
        bit busy_ok  = 1'b1;
        int done_at  = -1;
        int done_cnt = 0;
        bits = '0;
        gap  = 0;
        for (int c = 0; c < 4000 && !found; c++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
            else gap++;
        end
        check({tag, "_start_seen"}, 32'(found), 32'd1);
        if (!found) return;
        for (int i = 0; i < NBITS * CPB; i++) begin
            if (i > 0) @(negedge clk);
            if (i % CPB == 0) bits[i / CPB] = tx;
            else if (tx !== bits[i / CPB]) stable = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (tx_done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
        check({tag, "_bit_stable"}, 32'(stable), 32'd1);
        check({tag, "_busy_high"}, 32'(busy_ok), 32'd1);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_frame_len"}, 32'(done_at + 1), 32'(NBITS * CPB));
    endtask

    typedef struct {
        string         name;
        logic [DW-1:0] data;
        logic [9:0]    frame;  // stop, data[7:0], start (bit 0 sent first)
        logic          par;
    } vec_t;
    vec_t vecs[7];

    logic [10:0] bits;
    logic [10:0] exp_bits;
    int          gap;
    int          p0;
    int          bad;

    initial begin
        vecs[0] = '{"a5", 8'hA5, 10'b1_1010_0101_0, 1'b0};
        vecs[1] = '{"07", 8'h07, 10'b1_0000_0111_0, 1'b1};
        vecs[2] = '{"03", 8'h03, 10'b1_0000_0011_0, 1'b0};
        vecs[3] = '{"00", 8'h00, 10'b1_0000_0000_0, 1'b0};
        vecs[4] = '{"ff", 8'hFF, 10'b1_1111_1111_0, 1'b0};
        vecs[5] = '{"80", 8'h80, 10'b1_1000_0000_0, 1'b1};
        vecs[6] = '{"3c", 8'h3C, 10'b1_0011_1100_0, 1'b0};

        // reset with FIFO empty
        rst         = 1'b1;
        force_empty = 1'b0;
        wr_ptr      = '0;
        repeat (5) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        check("idle_100_cycles", 32'(bad), 32'd0);
        check("idle_no_pop", 32'(rd_pulses), 32'd0);

        // table-driven single frames
        foreach (vecs[k]) begin
            p0 = rd_pulses;
            push(vecs[k].data);
            get_frame(vecs[k].name, bits, gap);
`ifdef FIFO_UART_TX_PARITY_EN
            exp_bits = {1'b1, vecs[k].par, vecs[k].frame[8:0]};
`else
            exp_bits = {1'b0, vecs[k].frame};
`endif
            check({vecs[k].name, "_frame"}, 32'(bits), 32'(exp_bits));
            @(negedge clk);
            check({vecs[k].name, "_idle_after"}, 32'({tx, busy}), 32'b10);
            check({vecs[k].name, "_one_pop"}, 32'(rd_pulses - p0), 32'd1);
        end

        // 16 back-to-back frames
        p0 = rd_pulses;
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            exp_q.push_back(8'(i));
        end
        for (int i = 0; i < 16; i++) begin
            get_frame($sformatf("b2b%0d", i), bits, gap);
            if (exp_q.size() > 0) check($sformatf("b2b%0d_data", i), 32'(bits[8:1]), 32'(exp_q.pop_front()));
            check($sformatf("b2b%0d_stop", i), 32'(bits[NBITS-1]), 32'd1);
`ifdef FIFO_UART_TX_PARITY_EN
            check($sformatf("b2b%0d_parity", i), 32'(bits[9]), 32'(^bits[8:1]));
`endif
            if (i > 0) check($sformatf("b2b%0d_gap", i), 32'(gap), 32'd3);
        end
        check("b2b_pops", 32'(rd_pulses - p0), 32'd16);

        // reset in the middle of DATA for 0x3C; 0x5A must follow
        p0 = rd_pulses;
        push(8'h3C);
        push(8'h5A);
        bad = 1;
        for (int c = 0; c < 100 && bad == 1; c++) begin
            @(negedge clk);
            if (tx === 1'b0) bad = 0;
        end
        check("mid_rst_start_seen", 32'(bad), 32'd0);
        repeat (CPB + 3 * CPB + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_no_pop", 32'(fifo_rd_en), 32'd0);
        rst = 1'b0;
        get_frame("after_rst", bits, gap);
        check("after_rst_data", 32'(bits[8:1]), 32'h5A);
        check("after_rst_pops", 32'(rd_pulses - p0), 32'd2);

        // fifo_empty raised mid-frame
        p0 = rd_pulses;
        push(8'h96);
        push(8'h69);
        fork
            get_frame("empty_mid", bits, gap);
            begin
                repeat (60) @(negedge clk);
                force_empty = 1'b1;
            end
        join
        check("empty_mid_data", 32'(bits[8:1]), 32'h96);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("empty_hold_idle", 32'(bad), 32'd0);
        check("empty_hold_pops", 32'(rd_pulses - p0), 32'd1);
        force_empty = 1'b0;
        get_frame("empty_resume", bits, gap);
        check("empty_resume_data", 32'(bits[8:1]), 32'h69);
        check("empty_resume_pops", 32'(rd_pulses - p0), 32'd2);

        check("rd_en_while_empty", 32'(rd_viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
